// File: rtl/gb_timer.sv
// DIV/TIMA/TMA/TAC timer: free-running system counter, falling-edge driven TIMA
// with delayed TMA reload and interrupt pulse. Registers live at a 2-bit local address.
module gb_timer #(
    parameter int DIV_WIDTH    = 16,
    parameter int RELOAD_DELAY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       tick,
    output logic       timer_irq
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_OVF    = 2'd1,
        ST_RELOAD = 2'd2
    } state_t;

    localparam logic [3:0] DELAY_INIT = 4'(RELOAD_DELAY - 1);

    state_t                 state_reg, state_next;
    logic [DIV_WIDTH-1:0]   sys_cnt_reg, sys_cnt_next;
    logic [7:0]             tima_reg, tima_next;
    logic [7:0]             tma_reg, tma_next;
    logic [2:0]             tac_reg, tac_next;
    logic [3:0]             delay_reg, delay_next;
    logic                   prev_sel_reg;
    logic                   tick_reg;
    logic [7:0]             rdata_reg, rdata_next;

    logic wr_div, wr_tima, wr_tma, wr_tac, rd_en;
    logic cnt_bit, sel, edge_evt;

    assign wr_div  = cs & we & (addr == 2'd0);
    assign wr_tima = cs & we & (addr == 2'd1);
    assign wr_tma  = cs & we & (addr == 2'd2);
    assign wr_tac  = cs & we & (addr == 2'd3);
    assign rd_en   = cs & ~we;

    // Frequency select taps the system counter at bit 9/3/5/7.
    always_comb begin
        cnt_bit = 1'b0;
        unique case (tac_reg[1:0])
            2'b00: cnt_bit = sys_cnt_reg[9];
            2'b01: cnt_bit = sys_cnt_reg[3];
            2'b10: cnt_bit = sys_cnt_reg[5];
            2'b11: cnt_bit = sys_cnt_reg[7];
            default: cnt_bit = 1'b0;
        endcase
    end

    // Falling edge of the gated tap; DIV/TAC writes can create these glitch edges.
    assign sel      = tac_reg[2] & cnt_bit;
    assign edge_evt = prev_sel_reg & ~sel;

    always_comb begin
        sys_cnt_next = wr_div ? '0 : sys_cnt_reg + DIV_WIDTH'(1);
        tma_next     = wr_tma ? wdata : tma_reg;
        tac_next     = wr_tac ? wdata[2:0] : tac_reg;
    end

    always_comb begin
        rdata_next = rdata_reg;
        if (rd_en) begin
            unique case (addr)
                2'd0: rdata_next = sys_cnt_reg[DIV_WIDTH-1 -: 8];
                2'd1: rdata_next = tima_reg;
                2'd2: rdata_next = tma_reg;
                2'd3: rdata_next = {5'b11111, tac_reg};
                default: rdata_next = rdata_reg;
            endcase
        end
    end

    // TIMA sequencing: RUN counts, OVF holds zero for the delay, RELOAD loads TMA.
    always_comb begin
        state_next = state_reg;
        delay_next = delay_reg;
        tima_next  = tima_reg;
        timer_irq  = 1'b0;
        unique case (state_reg)
            ST_RUN: begin
                if (wr_tima) begin
                    tima_next = wdata;
                end else if (edge_evt) begin
                    if (tima_reg == 8'hFF) begin
                        tima_next = 8'h00;
                        if (RELOAD_DELAY > 1) begin
                            state_next = ST_OVF;
                            delay_next = DELAY_INIT;
                        end else begin
                            state_next = ST_RELOAD;
                            delay_next = 4'd0;
                        end
                    end else begin
                        tima_next = tima_reg + 8'd1;
                    end
                end
            end
            ST_OVF: begin
                if (wr_tima) begin
                    tima_next  = wdata;
                    state_next = ST_RUN;
                    delay_next = 4'd0;
                end else begin
                    delay_next = delay_reg - 4'd1;
                    if (delay_reg == 4'd1) begin
                        state_next = ST_RELOAD;
                    end
                end
            end
            ST_RELOAD: begin
                // A same-cycle TMA write is already reflected in tma_next.
                tima_next  = tma_next;
                timer_irq  = 1'b1;
                state_next = ST_RUN;
                delay_next = 4'd0;
            end
            default: begin
                state_next = ST_RUN;
                delay_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_RUN;
            sys_cnt_reg  <= '0;
            tima_reg     <= 8'h00;
            tma_reg      <= 8'h00;
            tac_reg      <= 3'b000;
            delay_reg    <= 4'd0;
            prev_sel_reg <= 1'b0;
            tick_reg     <= 1'b0;
            rdata_reg    <= 8'h00;
        end else begin
            state_reg    <= state_next;
            sys_cnt_reg  <= sys_cnt_next;
            tima_reg     <= tima_next;
            tma_reg      <= tma_next;
            tac_reg      <= tac_next;
            delay_reg    <= delay_next;
            prev_sel_reg <= sel;
            tick_reg     <= edge_evt;
            rdata_reg    <= rdata_next;
        end
    end

    assign rdata = rdata_reg;
    assign tick  = tick_reg;

endmodule
